// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode, ALU-op and writeback encodings plus the control word shared by the control unit
package mips_ctrl_pkg;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_LHU   = 6'b100101;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_SH    = 6'b101001;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_OR    = 4'b0011;
   localparam logic [3:0] ALU_SLT   = 4'b0100;
   localparam logic [3:0] ALU_SLTU  = 4'b0101;
   localparam logic [3:0] ALU_RTYPE = 4'b1111;
   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_LUI = 2'b10;
   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic [1:0] mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic [3:0] alu_op;
   } ctrl_t;
   localparam ctrl_t CTRL_NOP = '0;
endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: combinational opcode to control word; unknown or X opcodes fall to a NOP word
module mips_ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] i_opcode,
   output ctrl_t      o_ctrl
);
   always_comb begin
      o_ctrl = CTRL_NOP;
      case (i_opcode)
         OP_RTYPE:                o_ctrl = '{1'b1, 1'b0, WB_ALU, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_RTYPE};
         OP_ADDI, OP_ADDIU:       o_ctrl = '{1'b0, 1'b1, WB_ALU, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD};
         OP_ANDI:                 o_ctrl = '{1'b0, 1'b1, WB_ALU, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_AND};
         OP_ORI:                  o_ctrl = '{1'b0, 1'b1, WB_ALU, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_OR};
         OP_SLTI:                 o_ctrl = '{1'b0, 1'b1, WB_ALU, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_SLT};
         OP_SLTIU:                o_ctrl = '{1'b0, 1'b1, WB_ALU, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_SLTU};
         OP_LUI:                  o_ctrl = '{1'b0, 1'b1, WB_LUI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD};
         OP_LW, OP_LBU, OP_LHU:   o_ctrl = '{1'b0, 1'b1, WB_MEM, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD};
         OP_SB, OP_SH, OP_SW:     o_ctrl = '{1'b0, 1'b1, WB_ALU, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALU_ADD};
         OP_BEQ:                  o_ctrl = '{1'b0, 1'b0, WB_ALU, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_SUB};
         OP_J:                    o_ctrl = '{1'b0, 1'b0, WB_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD};
         default:                 o_ctrl = CTRL_NOP;
      endcase
   end
endmodule

// File: rtl/mips_control_unit.sv
// mips_control_unit: main MIPS control decoder with one registered stage, cleared to NOP by async reset
module mips_control_unit
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] InstrOpCode,
   output logic       RegDst,
   output logic       Jump,
   output logic       Branch,
   output logic       MemRead,
   output logic [1:0] MemtoReg,
   output logic [3:0] ALUOpSignal,
   output logic       MemWrite,
   output logic       ALUSrc,
   output logic       RegWrite
);
   ctrl_t w_ctrl;
   ctrl_t r_ctrl;
   mips_ctrl_decode u_decode (
      .i_opcode (InstrOpCode),
      .o_ctrl   (w_ctrl)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ctrl <= CTRL_NOP;
      else        r_ctrl <= w_ctrl;
   end
   assign RegDst      = r_ctrl.reg_dst;
   assign ALUSrc      = r_ctrl.alu_src;
   assign MemtoReg    = r_ctrl.mem_to_reg;
   assign RegWrite    = r_ctrl.reg_write;
   assign MemRead     = r_ctrl.mem_read;
   assign MemWrite    = r_ctrl.mem_write;
   assign Branch      = r_ctrl.branch;
   assign Jump        = r_ctrl.jump;
   assign ALUOpSignal = r_ctrl.alu_op;
endmodule

// File: tb/tb_mips_control_unit.sv
// tb_mips_control_unit: randomized and directed checks of the control unit against a category-based model
module tb_mips_control_unit;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] op = 6'b000000;
   logic       RegDst, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite;
   logic [1:0] MemtoReg;
   logic [3:0] ALUOpSignal;
   logic [12:0] exp_word;
   int checks = 0;
   int errors = 0;
   logic [5:0] listed [16] = '{6'd0, 6'd8, 6'd9, 6'd12, 6'd13, 6'd10, 6'd11, 6'd15,
                               6'd35, 6'd36, 6'd37, 6'd40, 6'd41, 6'd43, 6'd4, 6'd2};

   mips_control_unit dut (
      .clk(clk), .rst_n(rst_n), .InstrOpCode(op),
      .RegDst(RegDst), .Jump(Jump), .Branch(Branch), .MemRead(MemRead),
      .MemtoReg(MemtoReg), .ALUOpSignal(ALUOpSignal), .MemWrite(MemWrite),
      .ALUSrc(ALUSrc), .RegWrite(RegWrite)
   );

   always #5 clk = ~clk;

   // Word order: RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite Branch Jump ALUOp
   function automatic logic [12:0] model(input logic [5:0] o);
      bit rt  = (o == 6'd0);
      bit imm = o inside {6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd15};
      bit ld  = o inside {6'd35, 6'd36, 6'd37};
      bit st  = o inside {6'd40, 6'd41, 6'd43};
      bit bq  = (o == 6'd4);
      bit jp  = (o == 6'd2);
      logic [3:0] alu = rt ? 4'd15 : bq ? 4'd1 : o == 6'd12 ? 4'd2 : o == 6'd13 ? 4'd3 :
                        o == 6'd10 ? 4'd4 : o == 6'd11 ? 4'd5 : 4'd0;
      logic [1:0] wb = (o == 6'd15) ? 2'd2 : ld ? 2'd1 : 2'd0;
      return {rt, imm | ld | st, wb, rt | imm | ld, ld, st, bq, jp, alu};
   endfunction

   function automatic logic [12:0] dut_word();
      return {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOpSignal};
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) exp_word <= '0;
      else        exp_word <= model(op);

   task automatic check(input string name, input logic [12:0] got, input logic [12:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %b want %b (op=%b)", name, got, want, op);
      end
   endtask

   task automatic pin(input string name, input logic [5:0] o, input logic [12:0] want);
      op = o;
      @(negedge clk);
      check(name, dut_word(), want);
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            check("model", dut_word(), rst_n ? exp_word : 13'd0);
            check("inv_rdwr", {12'd0, MemRead & MemWrite}, 13'd0);
            check("inv_regwr", {12'd0, RegWrite & (MemWrite | Branch | Jump)}, 13'd0);
         end
      join_none
      @(negedge clk);
      check("reset_hold", dut_word(), 13'd0);
      rst_n = 1'b1;
      pin("rtype_after_release", 6'b000000, 13'b1_0_00_1_0_0_0_0_1111);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check("async_reset", dut_word(), 13'd0);
      @(negedge clk);
      rst_n = 1'b1;
      foreach (listed[i]) begin
         op = listed[i];
         @(negedge clk);
      end
      pin("lw", 6'b100011, 13'b0_1_01_1_1_0_0_0_0000);
      pin("sw", 6'b101011, 13'b0_1_00_0_0_1_0_0_0000);
      pin("beq", 6'b000100, 13'b0_0_00_0_0_0_1_0_0001);
      pin("j", 6'b000010, 13'b0_0_00_0_0_0_0_1_0000);
      pin("lui", 6'b001111, 13'b0_1_10_1_0_0_0_0_0000);
      pin("slti", 6'b001010, 13'b0_1_00_1_0_0_0_0_0100);
      pin("unk_3f", 6'b111111, 13'd0);
      pin("unk_01", 6'b000001, 13'd0);
      pin("rtype", 6'b000000, 13'b1_0_00_1_0_0_0_0_1111);
      repeat (1000) begin
         op = $urandom_range(0, 1) ? listed[$urandom_range(0, 15)] : 6'($urandom);
         @(negedge clk);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
